// File: rtl/snake_body_engine.sv
// snake_body_engine: snake segment store, one-cell movement per step, queued growth,
// wall-kill or torus-wrap edges, and a one-compare-per-cycle self-collision scan.
module snake_body_engine #(
   parameter int MAX_LEN  = 128,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int GRID_W   = 160,
   parameter int GRID_H   = 120,
   parameter int INIT_LEN = 10,
   parameter int INIT_X   = 80,
   parameter int INIT_Y   = 60,
   parameter int WRAP     = 0,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           step,
   input  logic           dir_valid,
   input  logic [1:0]     dir_in,
   input  logic           grow_valid,
   input  logic [3:0]     grow_amt,
   input  logic [LW-1:0]  rd_idx,
   output logic [X_W-1:0] rd_x,
   output logic [Y_W-1:0] rd_y,
   output logic           rd_valid,
   output logic [X_W-1:0] head_x,
   output logic [Y_W-1:0] head_y,
   output logic [LW-1:0]  length,
   output logic           busy,
   output logic           step_done,
   output logic           endgame
);
   localparam int IW = $clog2(MAX_LEN);
   localparam logic [X_W-1:0] XM = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] YM = Y_W'(GRID_H - 1);
   localparam logic [X_W-1:0] X1 = X_W'(1);
   localparam logic [Y_W-1:0] Y1 = Y_W'(1);
   localparam logic [LW-1:0] ONE = LW'(1);
   typedef enum logic [1:0] {IDLE, SCAN, DEAD} state_t;
   state_t state;
   logic [X_W-1:0] seg_x [MAX_LEN];
   logic [Y_W-1:0] seg_y [MAX_LEN];
   logic [1:0] dir, dir_pend;
   logic [7:0] pending, sat;
   logic [8:0] sum;
   logic [X_W-1:0] nx;
   logic [Y_W-1:0] ny;
   logic off, full, grows, hit;
   logic [LW-1:0] new_len, idx;
   assign head_x = seg_x[0];
   assign head_y = seg_y[0];
   always_comb begin
      sum = {1'b0, pending} + {5'b0, grow_valid ? grow_amt : 4'd0};
      sat = sum[8] ? 8'hff : sum[7:0];
      full = length == LW'(MAX_LEN);
      grows = !full && sat != 8'd0;
      new_len = length + (grows ? ONE : '0);
      off = (dir_pend == 2'b00 && seg_y[0] == '0) || (dir_pend == 2'b01 && seg_x[0] == XM) ||
            (dir_pend == 2'b10 && seg_x[0] == '0) || (dir_pend == 2'b11 && seg_y[0] == YM);
      nx = dir_pend == 2'b01 ? (seg_x[0] == XM ? '0 : seg_x[0] + X1) :
           dir_pend == 2'b10 ? (seg_x[0] == '0 ? XM : seg_x[0] - X1) : seg_x[0];
      ny = dir_pend == 2'b11 ? (seg_y[0] == YM ? '0 : seg_y[0] + Y1) :
           dir_pend == 2'b00 ? (seg_y[0] == '0 ? YM : seg_y[0] - Y1) : seg_y[0];
      hit = seg_x[idx[IW-1:0]] == seg_x[0] && seg_y[idx[IW-1:0]] == seg_y[0];
      rd_valid = rd_idx < length;
      rd_x = rd_idx < LW'(MAX_LEN) ? seg_x[rd_idx[IW-1:0]] : '0;
      rd_y = rd_idx < LW'(MAX_LEN) ? seg_y[rd_idx[IW-1:0]] : '0;
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= i < INIT_LEN ? X_W'(INIT_X - i) : '0;
            seg_y[i] <= i < INIT_LEN ? Y_W'(INIT_Y) : '0;
         end
         dir <= 2'b01;
         dir_pend <= 2'b01;
         length <= LW'(INIT_LEN);
         pending <= '0;
         idx <= ONE;
         busy <= 1'b0;
         step_done <= 1'b0;
         endgame <= 1'b0;
         state <= IDLE;
      end else begin
         step_done <= 1'b0;
         if (state != DEAD) begin
            if (dir_valid && dir_in != ~dir) dir_pend <= dir_in;
            pending <= sat;
         end
         case (state)
            IDLE: if (step) begin
               dir <= dir_pend;
               if (off && WRAP == 0) begin
                  endgame <= 1'b1;
                  state <= DEAD;
               end else begin
                  for (int i = 1; i < MAX_LEN; i++) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= nx;
                  seg_y[0] <= ny;
                  length <= new_len;
                  pending <= full ? '0 : grows ? sat - 8'd1 : sat;
                  idx <= ONE;
                  step_done <= new_len == ONE;
                  busy <= new_len != ONE;
                  state <= new_len == ONE ? IDLE : SCAN;
               end
            end
            SCAN: begin
               // idx never exceeds length-1, so every compare is against a live segment
               if (hit) begin
                  endgame <= 1'b1;
                  busy <= 1'b0;
                  state <= DEAD;
               end else if (idx == length - ONE) begin
                  step_done <= 1'b1;
                  busy <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx <= idx + ONE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed and random steps checked against a queue-based snake model.
module tb_snake_body_engine;
   localparam int MAX_LEN = 128, GW = 160, GH = 120;
   logic clock = 0, resetn = 0, step = 0, dir_valid = 0, grow_valid = 0;
   logic [1:0] dir_in = 0;
   logic [3:0] grow_amt = 0;
   logic [7:0] rd_idx = 0;
   logic [7:0] rd_x, head_x, rd_x_w, head_x_w, length, length_w;
   logic [6:0] rd_y, head_y, rd_y_w, head_y_w;
   logic rd_valid, busy, step_done, endgame, rd_valid_w, busy_w, step_done_w, endgame_w;
   int total = 0, bad = 0;
   int qx[$], qy[$];
   int mdir, mpd, mpend, goright;
   bit mdead;

   always #5 clock = ~clock;

   snake_body_engine #(.WRAP(0)) dut (
      .clock(clock), .resetn(resetn), .step(step), .dir_valid(dir_valid), .dir_in(dir_in),
      .grow_valid(grow_valid), .grow_amt(grow_amt), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
      .rd_valid(rd_valid), .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
      .step_done(step_done), .endgame(endgame));

   snake_body_engine #(.WRAP(1)) dut_w (
      .clock(clock), .resetn(resetn), .step(step), .dir_valid(dir_valid), .dir_in(dir_in),
      .grow_valid(grow_valid), .grow_amt(grow_amt), .rd_idx(rd_idx), .rd_x(rd_x_w), .rd_y(rd_y_w),
      .rd_valid(rd_valid_w), .head_x(head_x_w), .head_y(head_y_w), .length(length_w), .busy(busy_w),
      .step_done(step_done_w), .endgame(endgame_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int dx(input int d);
      return d == 1 ? 1 : d == 2 ? -1 : 0;
   endfunction

   function automatic int dy(input int d);
      return d == 0 ? -1 : d == 3 ? 1 : 0;
   endfunction

   task automatic do_reset();
      resetn = 0;
      @(posedge clock); #1;
      resetn = 1;
      qx = {};
      qy = {};
      for (int i = 0; i < 10; i++) begin
         qx.push_back(80 - i);
         qy.push_back(60);
      end
      mdir = 1; mpd = 1; mpend = 0; mdead = 0;
   endtask

   task automatic readback(input string tag);
      chk({tag, "_len"}, length, qx.size());
      chk({tag, "_hx"}, head_x, qx[0]);
      chk({tag, "_hy"}, head_y, qy[0]);
      chk({tag, "_end"}, endgame, mdead);
      chk({tag, "_busy"}, busy, 0);
      for (int i = 0; i < qx.size(); i++) begin
         rd_idx = 8'(i); #1;
         chk({tag, "_rx"}, rd_x, qx[i]);
         chk({tag, "_ry"}, rd_y, qy[i]);
         chk({tag, "_rv"}, rd_valid, 1);
      end
      if (qx.size() < MAX_LEN) begin
         rd_idx = 8'(qx.size()); #1;
         chk({tag, "_rv_past"}, rd_valid, 0);
      end
      for (int i = 128; i < 256; i += 127) begin
         rd_idx = 8'(i); #1;
         chk({tag, "_oob"}, {rd_valid, 7'(0), rd_x, 1'b0, rd_y}, 0);
      end
      rd_idx = 0;
      @(posedge clock); #1;
   endtask

   task automatic do_dir(input int d);
      dir_valid = 1; dir_in = 2'(d);
      @(posedge clock); #1;
      dir_valid = 0;
      if (!mdead && d != 3 - mdir) mpd = d;
   endtask

   task automatic do_grow(input int a);
      grow_valid = 1; grow_amt = 4'(a);
      @(posedge clock); #1;
      grow_valid = 0;
      if (!mdead) mpend = (mpend + a > 255) ? 255 : mpend + a;
   endtask

   task automatic do_step(input int ga, input bit poke, input string tag);
      int k, bc, expk, nx, ny, eff, sd;
      if (mdead) begin
         step = 1;
         @(posedge clock); #1;
         step = 0; sd = 0;
         repeat (12) begin
            @(posedge clock); #1;
            sd |= int'(step_done | busy);
         end
         chk({tag, "_dead_ignored"}, sd, 0);
         readback(tag);
         return;
      end
      mdir = mpd;
      nx = qx[0] + dx(mdir);
      ny = qy[0] + dy(mdir);
      eff = (mpend + ga > 255) ? 255 : mpend + ga;
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
         mdead = 1; mpend = eff; expk = 0;
      end else begin
         if (qx.size() == MAX_LEN) begin
            mpend = 0;
            void'(qx.pop_back()); void'(qy.pop_back());
         end else if (eff > 0) begin
            mpend = eff - 1;
         end else begin
            mpend = 0;
            void'(qx.pop_back()); void'(qy.pop_back());
         end
         qx.push_front(nx); qy.push_front(ny);
         expk = qx.size() - 1;
         for (int j = 1; j < qx.size(); j++)
            if (qx[j] == nx && qy[j] == ny) begin
               expk = j; mdead = 1;
               break;
            end
      end
      step = 1; grow_valid = ga > 0; grow_amt = 4'(ga);
      @(posedge clock); #1;
      step = 0; grow_valid = 0; k = 0; bc = 0;
      while (!step_done && !endgame && k < 300) begin
         bc += int'(busy);
         step = poke && k == 2;
         @(posedge clock); #1;
         k++;
      end
      step = 0;
      chk({tag, "_latency"}, k, expk);
      chk({tag, "_busy_cycles"}, bc, expk);
      chk({tag, "_done_flag"}, step_done, !mdead);
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, step_done, 0);
      readback(tag);
   endtask

   initial begin
      do_reset();
      chk("t1_done", step_done, 0);
      chk("t1_len_w", length_w, 10);
      readback("t1");
      do_step(0, 1, "t2");
      do_dir(2);
      do_step(0, 0, "t3_rev");
      do_dir(0);
      do_step(0, 0, "t3_up");
      do_grow(3);
      repeat (4) do_step(0, 0, "t4");
      do_step(2, 0, "t4_same");
      do_step(0, 0, "t4_after");
      do_step(0, 0, "t4_after2");
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: do_dir(int'($urandom_range(0, 3)));
            1: do_grow(int'($urandom_range(0, 15)));
            default: do_step(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0, 0, "rnd");
         endcase
      end
      do_reset();
      repeat (79) do_step(0, 0, "t5_run");
      chk("t5_wrap_pre_x", head_x_w, 159);
      do_step(0, 0, "t5_wall");
      chk("t5_wrap_x", head_x_w, 0);
      chk("t5_wrap_y", head_y_w, 60);
      chk("t5_wrap_end", endgame_w, 0);
      do_step(0, 0, "t5_ignored");
      do_grow(4);
      do_dir(0);
      do_step(0, 0, "t5_ignored2");
      do_reset();
      do_dir(0);
      do_step(0, 0, "t6_up");
      do_dir(2);
      do_step(0, 0, "t6_left");
      do_dir(3);
      do_step(0, 0, "t6_down");
      do_reset();
      step = 1;
      @(posedge clock); #1;
      step = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("t6_busy_mid", busy, 1);
      resetn = 0;
      @(posedge clock); #1;
      resetn = 1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", step_done, 0);
      readback("t6_rst");
      do_reset();
      repeat (18) do_grow(15);
      goright = 1;
      for (int s = 0; s < 125; s++) begin
         if (mdir == 1 && qx[0] >= 150) begin
            do_dir(3); goright = 0;
         end else if (mdir == 2 && qx[0] <= 10) begin
            do_dir(3); goright = 1;
         end else if (mdir == 3) begin
            do_dir(goright ? 1 : 2);
         end
         do_step(0, 0, "serp");
      end
      do_grow(5);
      do_step(0, 0, "full_hold");
      do_step(0, 0, "full_hold2");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
